multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle integer datapath: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) around one shared ALU.
// Optional JAL/JALR support is enabled by defining MULTICYCLE_DATAPATH_JAL_EN.
module multicycle_datapath #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] INITIAL_PC = XLEN'(32'h0040_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            iAck,
  input  logic [XLEN-1:0] dReadData,
  input  logic            dAck,
  output logic [XLEN-1:0] PC,
  output logic            iReq,
  output logic            dReq,
  output logic            dWe,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  output logic [XLEN-1:0] WriteBackData,
  output logic            retire,
  output logic            illegal,
  output logic [2:0]      state
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTICYCLE_DATAPATH_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  logic [2:0]      state_q, state_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [XLEN-1:0] regs_q [32];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  logic is_r, is_i, is_load, is_store, is_branch, is_jump, legal;
  assign is_r      = opcode == OP_R;
  assign is_i      = opcode == OP_I;
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
`ifdef MULTICYCLE_DATAPATH_JAL_EN
  logic is_jal, is_jalr;
  assign is_jal  = opcode == OP_JAL;
  assign is_jalr = opcode == OP_JALR;
  assign is_jump = is_jal | is_jalr;
`else
  assign is_jump = 1'b0;
`endif
  assign legal = is_r | is_i | is_load | is_store | is_branch | is_jump;

  // Immediate format follows the opcode; I-format is the fallback
  logic [31:0] imm32;
  always_comb begin
    imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_STORE:  imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
`ifdef MULTICYCLE_DATAPATH_JAL_EN
      OP_JAL:    imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
`endif
      default:   ;
    endcase
  end

  logic [XLEN-1:0]        op2, alu_res, exec_res, pc_plus4, wb_data;
  logic signed [XLEN-1:0] sra_res;
  logic [SHW-1:0]         shamt;
  logic                   br_taken;

  assign op2      = is_r ? b_q : imm_q;
  assign shamt    = op2[SHW-1:0];
  assign sra_res  = $signed(a_q) >>> shamt;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_taken = funct3[0] ? (a_q != b_q) : (a_q == b_q);

  always_comb begin
    alu_res = a_q + op2;
    case (funct3)
      3'b000:  alu_res = (is_r && ir_q[30]) ? a_q - op2 : a_q + op2;
      3'b001:  alu_res = a_q << shamt;
      3'b010:  alu_res = XLEN'($signed(a_q) < $signed(op2));
      3'b011:  alu_res = XLEN'(a_q < op2);
      3'b100:  alu_res = a_q ^ op2;
      3'b101:  alu_res = ir_q[30] ? sra_res : a_q >> shamt;
      3'b110:  alu_res = a_q | op2;
      default: alu_res = a_q & op2;
    endcase
  end

  // ALUOut doubles as memory address and jump target
  always_comb begin
    exec_res = alu_res;
    if (is_load || is_store) exec_res = a_q + imm_q;
`ifdef MULTICYCLE_DATAPATH_JAL_EN
    else if (is_jal)  exec_res = pc_q + imm_q;
    else if (is_jalr) exec_res = (a_q + imm_q) & ~XLEN'(1);
`endif
  end

  assign wb_data = is_load ? mdr_q : (is_jump ? pc_plus4 : alu_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (iAck) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_load || is_store)          state_d = S_MEM;
        else if (is_r || is_i || is_jump) state_d = S_WB;
        else                              state_d = S_FETCH;
      end
      S_MEM:    if (dAck) state_d = is_load ? S_WB : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Handshake and pulse outputs are forced low while reset is held
  always_comb begin
    iReq    = 1'b0;
    dReq    = 1'b0;
    dWe     = 1'b0;
    retire  = 1'b0;
    illegal = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: iReq = 1'b1;
        S_EXEC: begin
          retire  = is_branch;
          illegal = !legal;
        end
        S_MEM: begin
          dReq   = 1'b1;
          dWe    = is_store;
          retire = is_store & dAck;
        end
        S_WB:    retire = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q  <= '0;
      pc_q  <= INITIAL_PC;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (iAck) ir_q <= instr;
        S_DECODE: begin
          a_q   <= regs_q[rs1];
          b_q   <= regs_q[rs2];
          imm_q <= XLEN'($signed(imm32));
        end
        S_EXEC: begin
          alu_q <= exec_res;
          if (is_branch)   pc_q <= br_taken ? pc_q + imm_q : pc_plus4;
          else if (!legal) pc_q <= pc_plus4;
        end
        S_MEM: begin
          if (dAck) begin
            if (is_load) mdr_q <= XLEN'($signed(dReadData[31:0]));
            else         pc_q  <= pc_plus4;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs_q[rd] <= wb_data;
          pc_q <= is_jump ? alu_q : pc_plus4;
        end
        default: ;
      endcase
    end
  end

  assign PC            = pc_q;
  assign dAddress      = alu_q;
  assign dWriteData    = b_q;
  assign WriteBackData = wb_data;
  assign state         = state_q;
endmodule
